// File: rtl/decode_issue_ctrl_pkg.sv
// Shared RV32I ISA constants and IF/ID issue state for the decode_issue_ctrl slice.
// The optional ECALL/EBREAK halt is enabled with DECODE_HALT_EN.
package decode_issue_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int IMM_I_LSB  = 20;

    localparam logic [11:0] IMM_ECALL  = 12'h000;
    localparam logic [11:0] IMM_EBREAK = 12'h001;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        HALT  = 2'd2
    } issue_state_t;

    function automatic logic is_sys(input logic [31:0] instr);
        return (instr[6:0] == OPC_SYSTEM) &&
               (instr[FUNCT3_LSB +: 3] == 3'b000) &&
               ((instr[IMM_I_LSB +: 12] == IMM_ECALL) ||
                (instr[IMM_I_LSB +: 12] == IMM_EBREAK));
    endfunction

endpackage

// File: rtl/decode_issue_ctrl_load_use.sv
// Load-use hazard detector: decodes which source registers an instruction reads
// and compares them against a load destination sitting in EX.
module load_use_detect
    import decode_issue_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [31:0]       instr,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              hazard
);

    logic              rs1_used;
    logic              rs2_used;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              unused_instr_bits;

    assign rs1 = instr[RS1_LSB +: REG_AW];
    assign rs2 = instr[RS2_LSB +: REG_AW];
    assign unused_instr_bits = ^{instr[31:25], instr[14:7]};

    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (instr[6:0])
            OPC_OP, OPC_STORE, OPC_BRANCH: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                rs1_used = 1'b1;
            end
            // Register fields of these formats hold immediate bits, not sources.
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM: begin
                rs1_used = 1'b0;
            end
            default: begin
                rs1_used = 1'b0;
            end
        endcase
    end

    assign hazard = ex_valid && ex_is_load && (ex_rd != '0) &&
                    ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));

endmodule

// File: rtl/decode_issue_ctrl.sv
// IF/ID pipeline register and issue controller with load-use stall and redirect flush.
// Defining DECODE_HALT_EN adds a HALT state entered after issuing ECALL/EBREAK.
module decode_issue_ctrl
    import decode_issue_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_ready,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_instr,
    output logic [XLEN-1:0]   id_pc,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              redirect,
    input  logic              resume,
    output logic              halted
);

    issue_state_t    state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            hazard;
    logic            fire;
    logic            accept;
    logic            sys;

    load_use_detect #(
        .REG_AW(REG_AW)
    ) u_load_use_detect (
        .instr      (instr_q),
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .hazard     (hazard)
    );

`ifdef DECODE_HALT_EN
    assign sys    = is_sys(instr_q);
    assign halted = (state_q == HALT);
`else
    logic unused_resume;
    assign sys           = 1'b0;
    assign halted        = 1'b0;
    assign unused_resume = resume;
`endif

    assign id_valid = (state_q == FULL) && !hazard && !redirect;
    assign fire     = id_valid && id_ready;
    // A refill in FULL only happens in the same cycle the held instruction leaves.
    assign if_ready = rst_n && !redirect &&
                      ((state_q == EMPTY) || ((state_q == FULL) && fire && !sys));
    assign accept   = if_valid && if_ready;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (redirect) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = FULL;
                        instr_d = if_instr;
                        pc_d    = if_pc;
                    end
                end
                FULL: begin
                    if (fire) begin
`ifdef DECODE_HALT_EN
                        if (sys) begin
                            state_d = HALT;
                        end else
`endif
                        if (accept) begin
                            instr_d = if_instr;
                            pc_d    = if_pc;
                        end else begin
                            state_d = EMPTY;
                        end
                    end
                end
`ifdef DECODE_HALT_EN
                HALT: begin
                    if (resume) begin
                        state_d = EMPTY;
                    end
                end
`endif
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign id_instr = instr_q;
    assign id_pc    = pc_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Self-checking bench for decode_issue_ctrl: hazard vector table plus stream, stall,
// flush, halt and reset sequences, with a scoreboard of instructions expected to issue.
module tb_decode_issue_ctrl;

    localparam logic [31:0] I_ADD    = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_ADD0   = 32'h000001B3; // add  x3,x0,x0
    localparam logic [31:0] I_ADDI   = 32'h00510093; // addi x1,x2,5
    localparam logic [31:0] I_LUI    = 32'h123452B7; // lui  x5,0x12345
    localparam logic [31:0] I_SW     = 32'h0020A023; // sw   x2,0(x1)
    localparam logic [31:0] I_BEQ    = 32'h00208063; // beq  x1,x2,0
    localparam logic [31:0] I_LW     = 32'h00032283; // lw   x5,0(x6)
    localparam logic [31:0] I_JALR   = 32'h000380E7; // jalr x1,0(x7)
    localparam logic [31:0] I_JAL    = 32'h0080006F; // jal  x0,8
    localparam logic [31:0] I_AUIPC  = 32'h00103297; // auipc x5,0x103
    localparam logic [31:0] I_UNK    = 32'h0020807F;
    localparam logic [31:0] I_EBREAK = 32'h00100073;
`ifdef DECODE_HALT_EN
    localparam logic EBREAK_IFR = 1'b0;
`else
    localparam logic EBREAK_IFR = 1'b1;
`endif

    typedef struct {
        logic [31:0] instr;
        logic        ev;
        logic        el;
        logic [4:0]  rd;
        logic        rdy;
        logic        rdr;
        logic        exp_idv;
        logic        exp_ifr;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        ex_valid;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        redirect;
    logic        resume;
    logic        halted;

    int   total = 0;
    int   bad   = 0;
    sb_t  exp_q[$];
    vec_t vec[$];

    decode_issue_ctrl #(.XLEN(32), .REG_AW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_ready   (if_ready),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .redirect   (redirect),
        .resume     (resume),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input logic ev, input logic el,
                                input logic [4:0] rd, input logic rdy, input logic rdr,
                                input logic eiv, input logic eir);
        vec_t v;
        v.instr = instr; v.ev = ev; v.el = el; v.rd = rd;
        v.rdy = rdy; v.rdr = rdr; v.exp_idv = eiv; v.exp_ifr = eir;
        return v;
    endfunction

    task automatic idle();
        if_valid   = 1'b0;
        if_instr   = 32'h0;
        if_pc      = 32'h0;
        id_ready   = 1'b0;
        ex_valid   = 1'b0;
        ex_is_load = 1'b0;
        ex_rd      = 5'd0;
        redirect   = 1'b0;
        resume     = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc, input logic push);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        if (push) exp_q.push_back('{instr, pc});
    endtask

    task automatic drop_last();
        if (exp_q.size() > 0) void'(exp_q.pop_back());
    endtask

    // Scoreboard: every issue must match the oldest expected instruction.
    always @(negedge clk) begin
        if (rst_n && id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: issued pc=%h instr=%h, expected no issue", id_pc, id_instr);
            end else begin
                sb_t e;
                e = exp_q.pop_front();
                $display("issue pc=%h instr=%h (expected pc=%h instr=%h)", id_pc, id_instr, e.pc, e.instr);
                chk("sb_pc", id_pc, e.pc);
                chk("sb_instr", id_instr, e.instr);
            end
        end
    end

    initial begin
        vec.push_back(mk(I_ADD,   1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        vec.push_back(mk(I_ADD,   1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        vec.push_back(mk(I_ADD,   1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1));
        vec.push_back(mk(I_ADD,   1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1));
        vec.push_back(mk(I_ADD,   1'b0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1));
        vec.push_back(mk(I_ADD0,  1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1));
        vec.push_back(mk(I_LUI,   1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1));
        vec.push_back(mk(I_LUI,   1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1));
        vec.push_back(mk(I_ADDI,  1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        vec.push_back(mk(I_ADDI,  1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1));
        vec.push_back(mk(I_SW,    1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        vec.push_back(mk(I_SW,    1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        vec.push_back(mk(I_BEQ,   1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        vec.push_back(mk(I_BEQ,   1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        vec.push_back(mk(I_LW,    1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0));
        vec.push_back(mk(I_JALR,  1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0));
        vec.push_back(mk(I_JAL,   1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1));
        vec.push_back(mk(I_AUIPC, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1));
        vec.push_back(mk(I_UNK,   1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1));
        vec.push_back(mk(I_ADD,   1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        vec.push_back(mk(I_ADD,   1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0));
        vec.push_back(mk(I_EBREAK,1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, EBREAK_IFR));

        // Reset
        idle();
        rst_n = 1'b0;
        offer(I_ADDI, 32'h0, 1'b0);
        @(negedge clk);
        chk("rst_if_ready", {31'h0, if_ready}, 32'h0);
        next();
        next();
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        next();

        // Back-to-back stream
        idle();
        id_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) offer(I_ADDI, 32'(k * 4), 1'b1);
            else if_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("b2b%0d_id_valid", k), {31'h0, id_valid}, {31'h0, (k >= 1 && k <= 3)});
            if (k >= 1 && k <= 3) chk($sformatf("b2b%0d_id_pc", k), id_pc, 32'((k - 1) * 4));
            if (k < 3) chk($sformatf("b2b%0d_if_ready", k), {31'h0, if_ready}, 32'h1);
            next();
        end

        // Hazard decode table
        foreach (vec[i]) begin
            logic [31:0] pc;
            pc = 32'h1000 + 32'(i * 4);
            idle();
            offer(vec[i].instr, pc, 1'b1);
            @(negedge clk);
            chk($sformatf("vec%0d_load_if_ready", i), {31'h0, if_ready}, 32'h1);
            chk($sformatf("vec%0d_load_id_valid", i), {31'h0, id_valid}, 32'h0);
            next();
            idle();
            ex_valid = vec[i].ev; ex_is_load = vec[i].el; ex_rd = vec[i].rd;
            id_ready = vec[i].rdy; redirect = vec[i].rdr;
            @(negedge clk);
            $display("vec%0d instr=%h id_valid=%0b if_ready=%0b", i, vec[i].instr, id_valid, if_ready);
            chk($sformatf("vec%0d_id_valid", i), {31'h0, id_valid}, {31'h0, vec[i].exp_idv});
            chk($sformatf("vec%0d_if_ready", i), {31'h0, if_ready}, {31'h0, vec[i].exp_ifr});
            chk($sformatf("vec%0d_id_instr", i), id_instr, vec[i].instr);
            if (!(vec[i].exp_idv && vec[i].rdy)) drop_last();
            next();
            idle();
            redirect = 1'b1;
            next();
        end

        // Load-use stall then issue
        idle();
        offer(I_ADD, 32'h100, 1'b1);
        next();
        idle();
        id_ready = 1'b1; ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd1;
        offer(I_ADDI, 32'h104, 1'b0);
        @(negedge clk);
        chk("stall_id_valid", {31'h0, id_valid}, 32'h0);
        chk("stall_if_ready", {31'h0, if_ready}, 32'h0);
        next();
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;
        offer(I_ADDI, 32'h104, 1'b1);
        @(negedge clk);
        chk("stall_rel_id_valid", {31'h0, id_valid}, 32'h1);
        chk("stall_rel_id_pc", id_pc, 32'h100);
        chk("stall_rel_if_ready", {31'h0, if_ready}, 32'h1);
        next();
        if_valid = 1'b0;
        @(negedge clk);
        chk("stall_next_id_pc", id_pc, 32'h104);
        next();
        next();

        // Flush during hazard
        idle();
        offer(I_ADD, 32'h200, 1'b1);
        next();
        idle();
        id_ready = 1'b1; ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd2; redirect = 1'b1;
        offer(I_ADDI, 32'h204, 1'b0);
        @(negedge clk);
        chk("flush_id_valid", {31'h0, id_valid}, 32'h0);
        chk("flush_if_ready", {31'h0, if_ready}, 32'h0);
        drop_last();
        next();
        idle();
        id_ready = 1'b1;
        @(negedge clk);
        chk("flush_after_id_valid", {31'h0, id_valid}, 32'h0);
        chk("flush_after_if_ready", {31'h0, if_ready}, 32'h1);
        next();

        // ECALL/EBREAK handling
        idle();
        offer(I_EBREAK, 32'h300, 1'b1);
        next();
        idle();
        id_ready = 1'b1;
        @(negedge clk);
        chk("halt_fire_id_valid", {31'h0, id_valid}, 32'h1);
        chk("halt_fire_if_ready", {31'h0, if_ready}, {31'h0, EBREAK_IFR});
        next();
`ifdef DECODE_HALT_EN
        offer(I_ADDI, 32'h304, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("halt%0d_halted", k), {31'h0, halted}, 32'h1);
            chk($sformatf("halt%0d_if_ready", k), {31'h0, if_ready}, 32'h0);
            chk($sformatf("halt%0d_id_valid", k), {31'h0, id_valid}, 32'h0);
            next();
        end
        resume = 1'b1;
        @(negedge clk);
        chk("halt_resume_halted", {31'h0, halted}, 32'h1);
        chk("halt_resume_if_ready", {31'h0, if_ready}, 32'h0);
        next();
        resume = 1'b0;
        offer(I_ADDI, 32'h304, 1'b1);
        @(negedge clk);
        chk("halt_exit_halted", {31'h0, halted}, 32'h0);
        chk("halt_exit_if_ready", {31'h0, if_ready}, 32'h1);
        next();
        if_valid = 1'b0;
        next();
`else
        resume = 1'b1;
        @(negedge clk);
        chk("nohalt_halted", {31'h0, halted}, 32'h0);
        chk("nohalt_if_ready", {31'h0, if_ready}, 32'h1);
        next();
        resume = 1'b0;
        @(negedge clk);
        chk("nohalt_after_resume", {31'h0, halted}, 32'h0);
        next();
`endif

        // Mid-operation reset while FULL
        idle();
        offer(I_ADD, 32'h400, 1'b1);
        next();
        idle();
        rst_n = 1'b0;
        offer(I_ADDI, 32'h404, 1'b0);
        @(negedge clk);
        chk("mrst_if_ready", {31'h0, if_ready}, 32'h0);
        drop_last();
        next();
        idle();
        rst_n = 1'b1;
        id_ready = 1'b1;
        @(negedge clk);
        chk("mrst_id_valid", {31'h0, id_valid}, 32'h0);
        chk("mrst_id_instr", id_instr, 32'h0);
        chk("mrst_id_pc", id_pc, 32'h0);
        chk("mrst_halted", {31'h0, halted}, 32'h0);
        chk("mrst_if_ready_after", {31'h0, if_ready}, 32'h1);
        next();
        next();

        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
